// File: rtl/segway_cmd_seq_if.sv
// ============================================================================
// Module      : segway_cmd_seq_if
// Description : Request/UART-handshake bundle for segway_cmd_seq.
//               master : request source + UART_tx side (drives requests and
//                        tx_done, observes command/status outputs)
//               slave  : the sequencer itself
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface segway_cmd_seq_if;
    logic       go_req;
    logic       stop_req;
    logic       clr_err;
    logic       tx_done;
    logic       trmt;
    logic [7:0] tx_data;
    logic       busy;
    logic       running;
    logic [7:0] cmd_cnt;
    logic       timeout_err;

    modport master (
        output go_req, stop_req, clr_err, tx_done,
        input  trmt, tx_data, busy, running, cmd_cnt, timeout_err
    );

    modport slave (
        input  go_req, stop_req, clr_err, tx_done,
        output trmt, tx_data, busy, running, cmd_cnt, timeout_err
    );
endinterface

`default_nettype wire

// File: rtl/segway_cmd_seq.sv
// ============================================================================
// Module      : segway_cmd_seq
// Description : Turns go/stop requests into 'G' (0x47) / 'S' (0x53) bytes for
//               a UART transmitter. Owns the trmt/tx_data/tx_done handshake,
//               enforces an inter-command gap, optionally re-sends 'G' as a
//               keepalive while running, and flags a transmitter that never
//               completes.
// Ports       : clk, rst (async, active high)
//               bus.slave : go_req, stop_req, clr_err, tx_done in;
//                           trmt, tx_data[7:0], busy, running, cmd_cnt[7:0],
//                           timeout_err out (all registered)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module segway_cmd_seq #(
    parameter int GAP_CYC       = 1000,
    parameter int TX_TIMEOUT    = 1000000,
    parameter int KEEPALIVE_CYC = 0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    segway_cmd_seq_if.slave   bus
);

    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int TO_W  = $clog2(TX_TIMEOUT + 1);
    localparam int KA_W  = (KEEPALIVE_CYC > 0) ? $clog2(KEEPALIVE_CYC + 1) : 1;

    localparam logic [GAP_W-1:0] C_GAP   = GAP_W'(GAP_CYC);
    localparam logic [TO_W-1:0]  C_TO    = TO_W'(TX_TIMEOUT);
    localparam logic [KA_W-1:0]  C_KA    = KA_W'(KEEPALIVE_CYC);
    localparam bit               C_KA_EN = (KEEPALIVE_CYC != 0);
    localparam logic [7:0]       C_CMD_G = 8'h47;
    localparam logic [7:0]       C_CMD_S = 8'h53;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t             r_state_q,   w_state_d;
    logic               r_trmt_q,    w_trmt_d;
    logic [7:0]         r_tx_data_q, w_tx_data_d;
    logic               r_busy_q,    w_busy_d;
    logic               r_running_q, w_running_d;
    logic [7:0]         r_cmd_cnt_q, w_cmd_cnt_d;
    logic               r_err_q,     w_err_d;
    logic               r_pend_q,    w_pend_d;
    logic [GAP_W-1:0]   r_gap_q,     w_gap_d;
    logic [TO_W-1:0]    r_to_q,      w_to_d;
    logic [KA_W-1:0]    r_ka_q,      w_ka_d;

    always_comb begin
        w_state_d   = r_state_q;
        w_trmt_d    = 1'b0;
        w_tx_data_d = r_tx_data_q;
        w_running_d = r_running_q;
        w_cmd_cnt_d = r_cmd_cnt_q;
        w_err_d     = r_err_q;
        w_pend_d    = r_pend_q;
        // Counters clear whenever their owning state is left.
        w_gap_d     = '0;
        w_to_d      = '0;
        w_ka_d      = '0;

        // Clear first so a coincident timeout below takes priority.
        if (bus.clr_err) begin
            w_err_d = 1'b0;
        end

        case (r_state_q)
            S_IDLE: begin
                if (bus.stop_req) begin
                    w_tx_data_d = C_CMD_S;
                    w_running_d = 1'b0;
                    w_state_d   = S_LOAD;
                end else if (bus.go_req) begin
                    w_tx_data_d = C_CMD_G;
                    w_running_d = 1'b1;
                    w_state_d   = S_LOAD;
                end else if (C_KA_EN && r_running_q) begin
                    if (r_ka_q + 1'b1 == C_KA) begin
                        w_tx_data_d = C_CMD_G;
                        w_state_d   = S_LOAD;
                    end else begin
                        w_ka_d = r_ka_q + 1'b1;
                    end
                end
            end

            S_LOAD: begin
                // The LOAD cycle is the first cycle of the trmt-to-done window.
                w_to_d    = TO_W'(1);
                w_state_d = S_WAIT;
                if (bus.stop_req) begin
                    w_pend_d = 1'b1;
                end
            end

            S_WAIT: begin
                if (bus.stop_req) begin
                    w_pend_d = 1'b1;
                end
                if (bus.tx_done) begin
                    if (r_cmd_cnt_q != 8'hFF) begin
                        w_cmd_cnt_d = r_cmd_cnt_q + 8'd1;
                    end
                    w_state_d = S_GAP;
                end else if (r_to_q + 1'b1 >= C_TO) begin
                    w_err_d   = 1'b1;
                    w_pend_d  = 1'b0;
                    w_state_d = S_IDLE;
                end else begin
                    w_to_d = r_to_q + 1'b1;
                end
            end

            S_GAP: begin
                if (bus.stop_req) begin
                    w_pend_d = 1'b1;
                end
                if (r_gap_q + 1'b1 == C_GAP) begin
                    // A stop arriving on the final gap cycle is honoured too.
                    w_pend_d = 1'b0;
                    if (r_pend_q || bus.stop_req) begin
                        w_tx_data_d = C_CMD_S;
                        w_running_d = 1'b0;
                        w_state_d   = S_LOAD;
                    end else begin
                        w_state_d   = S_IDLE;
                    end
                end else begin
                    w_gap_d = r_gap_q + 1'b1;
                end
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        w_trmt_d = (r_state_q != S_LOAD) && (w_state_d == S_LOAD);
        w_busy_d = (w_state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q   <= S_IDLE;
            r_trmt_q    <= 1'b0;
            r_tx_data_q <= 8'h00;
            r_busy_q    <= 1'b0;
            r_running_q <= 1'b0;
            r_cmd_cnt_q <= 8'h00;
            r_err_q     <= 1'b0;
            r_pend_q    <= 1'b0;
            r_gap_q     <= '0;
            r_to_q      <= '0;
            r_ka_q      <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_trmt_q    <= w_trmt_d;
            r_tx_data_q <= w_tx_data_d;
            r_busy_q    <= w_busy_d;
            r_running_q <= w_running_d;
            r_cmd_cnt_q <= w_cmd_cnt_d;
            r_err_q     <= w_err_d;
            r_pend_q    <= w_pend_d;
            r_gap_q     <= w_gap_d;
            r_to_q      <= w_to_d;
            r_ka_q      <= w_ka_d;
        end
    end

    assign bus.trmt        = r_trmt_q;
    assign bus.tx_data     = r_tx_data_q;
    assign bus.busy        = r_busy_q;
    assign bus.running     = r_running_q;
    assign bus.cmd_cnt     = r_cmd_cnt_q;
    assign bus.timeout_err = r_err_q;

endmodule

`default_nettype wire

// File: tb/tb_segway_cmd_seq.sv
// ============================================================================
// Module      : tb_segway_cmd_seq
// Description : Self-checking bench for segway_cmd_seq. Main instance runs with
//               GAP_CYC=4, TX_TIMEOUT=100, KEEPALIVE_CYC=50; a second instance
//               with keepalive off shares the request inputs.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_segway_cmd_seq;

    localparam int GAP      = 4;
    localparam int TO       = 100;
    localparam int KA       = 50;
    localparam int UART_LAT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    segway_cmd_seq_if bus  ();
    segway_cmd_seq_if bus2 ();

    logic uart_en    = 1'b1;
    logic uart_done  = 1'b0;
    logic stray_done = 1'b0;
    logic uart2_done = 1'b0;
    int   uart_cnt   = 0;
    int   uart2_cnt  = 0;

    assign bus.tx_done   = uart_done | stray_done;
    assign bus2.go_req   = bus.go_req;
    assign bus2.stop_req = bus.stop_req;
    assign bus2.clr_err  = bus.clr_err;
    assign bus2.tx_done  = uart2_done;

    segway_cmd_seq #(.GAP_CYC(GAP), .TX_TIMEOUT(TO), .KEEPALIVE_CYC(KA)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    segway_cmd_seq #(.GAP_CYC(GAP), .TX_TIMEOUT(TO), .KEEPALIVE_CYC(0)) u_dut_noka (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // UART_tx models: tx_done pulses UART_LAT cycles after the trmt cycle.
    always @(negedge clk) begin
        uart_done = 1'b0;
        if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) uart_done = 1'b1;
        end
        if (bus.trmt && uart_en) uart_cnt = UART_LAT;
    end

    always @(negedge clk) begin
        uart2_done = 1'b0;
        if (uart2_cnt > 0) begin
            uart2_cnt--;
            if (uart2_cnt == 0) uart2_done = 1'b1;
        end
        if (bus2.trmt) uart2_cnt = UART_LAT;
    end

    int         n_checks  = 0;
    int         n_errors  = 0;
    int         exp_cnt   = 0;
    int         trmt2_cnt = 0;
    logic       trmt_prev = 1'b0;
    logic [7:0] exp_q[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Advance n cycles; every sample point also runs the byte scoreboard.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!rst) begin
                if (bus.trmt) begin
                    check("trmt_one_cycle", 32'(trmt_prev), 0);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL sb_unexpected: trmt with tx_data=0x%02h, no command expected", bus.tx_data);
                    end else begin
                        check("sb_tx_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                    end
                end
                if (bus2.trmt) trmt2_cnt++;
            end
            trmt_prev = bus.trmt;
        end
    endtask

    // Drive a request for one clock; returns in the cycle trmt should be high.
    task automatic req(input logic g, input logic s);
        bus.go_req   = g;
        bus.stop_req = s;
        tick(1);
        bus.go_req   = 1'b0;
        bus.stop_req = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (bus.busy && k < budget) begin
            tick(1);
            k++;
        end
        check({name, "_idle"}, 32'(bus.busy), 0);
    endtask

    function automatic void bump_cnt(input int n);
        exp_cnt = (exp_cnt + n > 255) ? 255 : exp_cnt + n;
    endfunction

    typedef struct {
        logic       go;
        logic       stop;
        logic       exp_trmt;
        logic [7:0] exp_byte;
        logic       exp_running;
    } vec_t;

    vec_t vt[6];

    initial begin
        vt[0] = '{go: 1'b1, stop: 1'b0, exp_trmt: 1'b1, exp_byte: 8'h47, exp_running: 1'b1};
        vt[1] = '{go: 1'b0, stop: 1'b1, exp_trmt: 1'b1, exp_byte: 8'h53, exp_running: 1'b0};
        vt[2] = '{go: 1'b1, stop: 1'b1, exp_trmt: 1'b1, exp_byte: 8'h53, exp_running: 1'b0};
        vt[3] = '{go: 1'b1, stop: 1'b0, exp_trmt: 1'b1, exp_byte: 8'h47, exp_running: 1'b1};
        vt[4] = '{go: 1'b0, stop: 1'b0, exp_trmt: 1'b0, exp_byte: 8'h00, exp_running: 1'b1};
        vt[5] = '{go: 1'b0, stop: 1'b1, exp_trmt: 1'b1, exp_byte: 8'h53, exp_running: 1'b0};

        bus.go_req   = 1'b0;
        bus.stop_req = 1'b0;
        bus.clr_err  = 1'b0;
        rst = 1'b0;
        #2 rst = 1'b1;
        tick(2);

        // Reset state
        check("rst_trmt",    32'(bus.trmt),        0);
        check("rst_tx_data", 32'(bus.tx_data),     0);
        check("rst_busy",    32'(bus.busy),        0);
        check("rst_running", 32'(bus.running),     0);
        check("rst_cmd_cnt", 32'(bus.cmd_cnt),     0);
        check("rst_err",     32'(bus.timeout_err), 0);
        rst = 1'b0;
        tick(2);

        // Single 'G' with cycle-accurate handshake timing (trmt cycle = t)
        exp_q.push_back(8'h47);
        req(1'b1, 1'b0);
        check("t1_trmt",    32'(bus.trmt),    1);
        check("t1_running", 32'(bus.running), 1);
        tick(1);
        check("t1_trmt_low", 32'(bus.trmt), 0);
        tick(2);
        check("t1_cnt_before_done", 32'(bus.cmd_cnt), 32'(exp_cnt));
        tick(1);
        bump_cnt(1);
        check("t1_cnt_after_done", 32'(bus.cmd_cnt), 32'(exp_cnt));
        tick(3);
        check("t1_busy_in_gap", 32'(bus.busy), 1);
        tick(1);
        check("t1_busy_low", 32'(bus.busy), 0);

        // Table-driven single requests from IDLE
        for (int i = 0; i < 6; i++) begin
            if (vt[i].exp_trmt) exp_q.push_back(vt[i].exp_byte);
            req(vt[i].go, vt[i].stop);
            check($sformatf("vec%0d_trmt", i), 32'(bus.trmt), 32'(vt[i].exp_trmt));
            check($sformatf("vec%0d_running", i), 32'(bus.running), 32'(vt[i].exp_running));
            if (vt[i].exp_trmt) begin
                wait_idle($sformatf("vec%0d", i), 40);
                bump_cnt(1);
            end else begin
                tick(10);
            end
            check($sformatf("vec%0d_cmd_cnt", i), 32'(bus.cmd_cnt), 32'(exp_cnt));
        end

        // stop (and a stray go) during WAIT of 'G': G, 4-cycle gap, then S
        exp_q.push_back(8'h47);
        exp_q.push_back(8'h53);
        req(1'b1, 1'b0);
        tick(1);
        bus.go_req   = 1'b1;
        bus.stop_req = 1'b1;
        tick(1);
        bus.go_req   = 1'b0;
        bus.stop_req = 1'b0;
        tick(5);
        check("t3_no_trmt_in_gap", 32'(bus.trmt), 0);
        tick(1);
        check("t3_pending_s_trmt", 32'(bus.trmt),    1);
        check("t3_running_low",    32'(bus.running), 0);
        wait_idle("t3", 40);
        bump_cnt(2);
        check("t3_cmd_cnt", 32'(bus.cmd_cnt), 32'(exp_cnt));
        tick(10);

        // Stray tx_done in IDLE is ignored
        stray_done = 1'b1;
        tick(1);
        stray_done = 1'b0;
        tick(2);
        check("stray_cmd_cnt", 32'(bus.cmd_cnt), 32'(exp_cnt));
        check("stray_busy",    32'(bus.busy),    0);

        // Timeout: tx_done never arrives
        uart_en = 1'b0;
        exp_q.push_back(8'h47);
        req(1'b1, 1'b0);
        tick(99);
        check("t4_err_before", 32'(bus.timeout_err), 0);
        check("t4_busy_before", 32'(bus.busy), 1);
        tick(1);
        check("t4_err_set",  32'(bus.timeout_err), 1);
        check("t4_busy_low", 32'(bus.busy),        0);
        check("t4_cnt_kept", 32'(bus.cmd_cnt),     32'(exp_cnt));
        uart_en     = 1'b1;
        bus.clr_err = 1'b1;
        tick(1);
        bus.clr_err = 1'b0;
        check("t4_err_cleared", 32'(bus.timeout_err), 0);
        exp_q.push_back(8'h53);
        req(1'b0, 1'b1);
        wait_idle("t4_stop", 40);
        bump_cnt(1);
        check("t4_stop_cnt", 32'(bus.cmd_cnt), 32'(exp_cnt));

        // Reset asserted mid-WAIT
        uart_en = 1'b0;
        exp_q.push_back(8'h47);
        req(1'b1, 1'b0);
        tick(5);
        rst = 1'b1;
        #1;
        check("t4_rst_trmt",    32'(bus.trmt),        0);
        check("t4_rst_tx_data", 32'(bus.tx_data),     0);
        check("t4_rst_busy",    32'(bus.busy),        0);
        check("t4_rst_running", 32'(bus.running),     0);
        check("t4_rst_cmd_cnt", 32'(bus.cmd_cnt),     0);
        check("t4_rst_err",     32'(bus.timeout_err), 0);
        exp_cnt = 0;
        tick(1);
        rst     = 1'b0;
        uart_en = 1'b1;
        tick(2);

        // Keepalive: G at t, first IDLE at t+8, re-sends at t+58 and t+116
        begin
            int t2_start;
            t2_start = trmt2_cnt;
            exp_q.push_back(8'h47);
            req(1'b1, 1'b0);
            check("t5_first_trmt", 32'(bus.trmt), 1);
            exp_q.push_back(8'h47);
            tick(57);
            check("t5_ka1_early", 32'(bus.trmt), 0);
            tick(1);
            check("t5_ka1", 32'(bus.trmt), 1);
            exp_q.push_back(8'h47);
            tick(57);
            check("t5_ka2_early", 32'(bus.trmt), 0);
            tick(1);
            check("t5_ka2", 32'(bus.trmt), 1);
            // stop while the keepalive is in LOAD: queued behind it
            exp_q.push_back(8'h53);
            bus.stop_req = 1'b1;
            tick(1);
            bus.stop_req = 1'b0;
            wait_idle("t5", 60);
            bump_cnt(4);
            check("t5_cmd_cnt", 32'(bus.cmd_cnt), 32'(exp_cnt));
            check("t5_running", 32'(bus.running), 0);
            tick(120);
            check("t5_noka_trmts", 32'(trmt2_cnt - t2_start), 2);
            check("t5_noka_running", 32'(bus2.running), 0);
        end

        // Saturation of the command counter
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back(8'h47);
            req(1'b1, 1'b0);
            wait_idle("t6", 40);
            bump_cnt(1);
            if (i % 100 == 99) check($sformatf("t6_cnt_%0d", i + 1), 32'(bus.cmd_cnt), 32'(exp_cnt));
        end
        check("t6_saturated", 32'(bus.cmd_cnt), 32'hFF);
        tick(5);

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
